// File: rtl/swin_frame_seq_pkg.sv
// Shared types and constants for the sliding-window frame sequencer.
package swin_frame_seq_pkg;

  localparam int unsigned FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/swin_frame_seq.sv
// Frame sequencer beside a 3x3 window: feeds one frame of source pixels,
// flushes the window with a border value, and checks the window's output count.
module swin_frame_seq
  import swin_frame_seq_pkg::*;
#(
  parameter int unsigned P_WIDTH     = 32,
  parameter int unsigned P_HEIGHT    = 24,
  parameter int unsigned DW          = 32,
  parameter int unsigned P_PIX_CNT_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [DW-1:0]          cfg_border,
  input  logic                   s_valid,
  input  logic [DW-1:0]          s_data,
  output logic                   s_ready,
  output logic                   win_din_valid,
  output logic [DW-1:0]          win_din,
  input  logic                   win_valid,
  input  logic                   win_last_pixel,
  output logic                   busy,
  output logic                   done,
  output logic                   frame_err,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int unsigned PIX_TOTAL   = P_WIDTH * P_HEIGHT;
  localparam int unsigned FLUSH_LIMIT = 2 * P_WIDTH + 4;
  localparam int unsigned FLUSH_CW    = $clog2(FLUSH_LIMIT + 1);
  localparam int unsigned OUT_CMP_W   = P_PIX_CNT_W + 1;

  state_e                 state_q;
  state_e                 state_d;
  logic [P_PIX_CNT_W-1:0] in_cnt_q;
  logic [P_PIX_CNT_W-1:0] out_cnt_q;
  logic [FLUSH_CW-1:0]    flush_cnt_q;
  logic [DW-1:0]          border_q;
  logic                   frame_err_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  logic start_acc;
  logic xfer;
  logic last_xfer;
  logic flush_timeout;
  logic out_short;
  logic err_set;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, error detection and pixel-path outputs
  always_comb begin
    state_d       = state_q;
    err_set       = 1'b0;
    s_ready       = 1'b0;
    win_din_valid = 1'b0;
    win_din       = '0;
    start_acc     = (state_q == ST_IDLE) && start;
    xfer          = (state_q == ST_FEED) && s_valid;
    last_xfer     = xfer && (in_cnt_q == P_PIX_CNT_W'(PIX_TOTAL - 1));
    flush_timeout = (flush_cnt_q == FLUSH_CW'(FLUSH_LIMIT - 1));
    // Count includes the output flagged last in this same cycle
    out_short     = (OUT_CMP_W'(out_cnt_q) + OUT_CMP_W'(1)) != OUT_CMP_W'(PIX_TOTAL);

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FEED;
      end
      ST_FEED: begin
        s_ready       = 1'b1;
        win_din_valid = s_valid;
        win_din       = s_data;
        if (win_last_pixel) begin
          state_d = ST_DONE;
          err_set = 1'b1;
        end else if (last_xfer) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        win_din_valid = 1'b1;
        win_din       = border_q;
        if (win_last_pixel) begin
          state_d = ST_DONE;
          err_set = out_short;
        end else if (flush_timeout) begin
          state_d = ST_DONE;
          err_set = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Frame counters, border latch and sticky error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      flush_cnt_q <= '0;
      border_q    <= '0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      if (start_acc) begin
        in_cnt_q    <= '0;
        out_cnt_q   <= '0;
        flush_cnt_q <= '0;
        border_q    <= cfg_border;
        frame_err_q <= 1'b0;
      end else begin
        if (xfer) in_cnt_q <= in_cnt_q + P_PIX_CNT_W'(1);
        if (busy && win_valid) out_cnt_q <= out_cnt_q + P_PIX_CNT_W'(1);
        if (state_q == ST_FLUSH) flush_cnt_q <= flush_cnt_q + FLUSH_CW'(1);
        if (err_set) frame_err_q <= 1'b1;
      end
      if (state_q == ST_DONE) frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
    end
  end

  assign busy      = (state_q == ST_FEED) || (state_q == ST_FLUSH);
  assign done      = (state_q == ST_DONE);
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/swin_frame_seq.md
SWIN_FRAME_SEQ -- requirements
Module: swin_frame_seq

Interface
REQ-001 Parameter P_WIDTH, default 32, frame width in pixels.
REQ-002 Parameter P_HEIGHT, default 24, frame height in lines.
REQ-003 Parameter DW, default 32, pixel data width.
REQ-004 Parameter P_PIX_CNT_W, default 10, pixel counter width; SHALL hold P_WIDTH*P_HEIGHT.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  frame-start request, sampled in IDLE only.
REQ-008 cfg_border  in  DW  flush pixel value, latched on accepted start.
REQ-009 s_valid  in  1  source pixel valid.
REQ-010 s_data  in  DW  source pixel.
REQ-011 s_ready  out  1  source ready; high only in FEED.
REQ-012 win_din_valid  out  1  pixel strobe to the 3x3 window.
REQ-013 win_din  out  DW  pixel to the 3x3 window.
REQ-014 win_valid  in  1  window output-valid.
REQ-015 win_last_pixel  in  1  window last-output-pixel flag.
REQ-016 busy  out  1  high in FEED or FLUSH.
REQ-017 done  out  1  one-cycle pulse at frame end.
REQ-018 frame_err  out  1  sticky error, cleared on next accepted start.
REQ-019 frame_cnt  out  16  completed frames, wraps at 65535->0.

Function
REQ-020 FSM states IDLE, FEED, FLUSH, DONE.
REQ-021 IDLE->FEED when start=1; in_cnt, out_cnt, flush_cnt cleared; cfg_border latched; frame_err cleared.
REQ-022 start outside IDLE SHALL be ignored.
REQ-023 FEED: s_ready=1; win_din_valid=s_valid; win_din=s_data combinationally (zero latency).
REQ-024 Each s_valid&s_ready increments in_cnt; transfer with in_cnt=P_WIDTH*P_HEIGHT-1 moves FSM to FLUSH next cycle.
REQ-025 FLUSH: s_ready=0; win_din_valid=1 every cycle; win_din=latched border; flush_cnt increments per cycle.
REQ-026 out_cnt increments on every win_valid while busy, in both FEED and FLUSH.
REQ-027 FLUSH->DONE on win_last_pixel; frame_err set if out_cnt+1 != P_WIDTH*P_HEIGHT.
REQ-028 win_last_pixel seen in FEED SHALL set frame_err and move FSM to DONE.
REQ-029 FLUSH timeout: flush_cnt reaching 2*P_WIDTH+4 without win_last_pixel SHALL set frame_err and move FSM to DONE.
REQ-030 DONE: done=1 for exactly one cycle; frame_cnt increments; FSM returns to IDLE next cycle.
REQ-031 Outside FEED/FLUSH: win_din_valid=0, win_din=0, s_ready=0.
REQ-032 win_valid/win_last_pixel in IDLE or DONE SHALL be ignored.

Reset
REQ-033 rst_n=0 at any clock edge, including mid-frame, SHALL force IDLE, all counters 0, cfg latch 0, frame_err=0, frame_cnt=0.
REQ-034 Reset values of outputs: s_ready=0, win_din_valid=0, win_din=0, busy=0, done=0, frame_err=0, frame_cnt=0.

Structure
REQ-035 Shared package holds the FSM state enum and the frame_cnt width constant (16).
REQ-036 The 3x3 window SHALL NOT be instantiated inside; the block connects beside it at the integration level.
REQ-037 Single module, no sub-modules; counters and FSM inline.

Verification (P_WIDTH=32, P_HEIGHT=24, DW=32)
REQ-038 Start, 768 pixels with pseudo-random s_valid gaps, window model asserting win_last_pixel on its 768th output -> done pulse once, frame_err=0, frame_cnt=1.
REQ-039 cfg_border=0xDEADBEEF -> every FLUSH-cycle win_din=0xDEADBEEF; no s_ready during FLUSH.
REQ-040 Window model withholds win_last_pixel -> FSM leaves FLUSH after 68 flush cycles, frame_err=1, done pulses.
REQ-041 win_last_pixel after only 767 win_valid -> frame_err=1 at DONE; next start clears frame_err.
REQ-042 rst_n=0 at in_cnt=400 -> next cycle IDLE, busy=0, frame_cnt=0; fresh frame afterwards completes with no error.
REQ-043 start pulsed during FEED and FLUSH -> no effect; frame_cnt advances by exactly 1.
